hd_encode_sequencer: RTL and testbench
======================================

Name: hd_encode_sequencer

Overview:
- Initiator side of the 32-lane mux accumulator used in the HD encoder.
- Accepts a stream of feature/projection chunks for one hypervector dimension and drives the accumulator's features/projections/prev_result inputs, one chunk at a time.
- Waits out the accumulator pipeline latency, captures its out, and feeds it back as prev_result for the next chunk.
- After the last chunk, presents the finished dimension value on a valid/ready output.

Parameters:
- INPUT_NUM, 32, lanes per chunk (matches accumulator)
- INPUT_WIDTH, 8, bits per feature
- DIM_WIDTH, 16, accumulated dimension value width
- ACC_LATENCY, 3, rising edges from accumulator inputs stable to out valid
- NUM_CHUNKS, 4, chunks per dimension (used only with the optional check)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  chunk available
- in_ready  out  1  sequencer accepts chunk
- in_features  in  INPUT_NUM*INPUT_WIDTH  feature chunk, lane i at bits [i*INPUT_WIDTH +: INPUT_WIDTH]
- in_projections  in  INPUT_NUM  projection bits (1 = +feature, 0 = -feature)
- in_last  in  1  chunk is the final one of the dimension
- acc_features  out  INPUT_NUM*INPUT_WIDTH  to accumulator features
- acc_projections  out  INPUT_NUM  to accumulator projections
- acc_prev_result  out  DIM_WIDTH  to accumulator prev_result
- acc_out  in  DIM_WIDTH  from accumulator out
- out_valid  out  1  dimension value valid
- out_ready  in  1  downstream accepts value
- out_data  out  DIM_WIDTH  finished dimension value
- err  out  1  chunk-count error; present only with HDSEQ_CHUNK_CHECK_EN

Behaviour:
- FSM states: ACCEPT, WAIT, OUTPUT.
- Reset (reset=0, asynchronous):
  - state=ACCEPT, first=1.
  - All acc_* registers, partial, and out_data are 0.
  - out_valid=0, err=0.
  - A reset asserted mid-WAIT or mid-OUTPUT abandons the dimension; no output is produced for it.
- ACCEPT:
  - in_ready=1 (combinational from state only).
  - On an edge with in_valid=1:
    - Register in_features to acc_features and in_projections to acc_projections.
    - acc_prev_result <= first ? 0 : partial.
    - Latch last_q <= in_last and set first <= 0.
    - Load wait counter with ACC_LATENCY; go to WAIT.
- WAIT:
  - in_ready=0; acc_* registers hold their values.
  - Counter decrements on each edge.
  - On the edge where counter==0: partial <= acc_out.
    - If last_q, then out_data <= acc_out, out_valid <= 1, go to OUTPUT.
    - Else go to ACCEPT.
  - acc_out is therefore sampled exactly ACC_LATENCY+1 edges after the accept edge.
  - Chunk throughput: one chunk per ACC_LATENCY+2 cycles at best.
- OUTPUT:
  - in_ready=0; out_valid and out_data held stable until the handshake.
  - On an edge with out_ready=1:
    - out_valid <= 0, first <= 1, partial <= 0.
    - Go to ACCEPT.
  - No combinational path from out_ready to in_ready; the next chunk is accepted no earlier than the cycle after the output handshake.
- Arithmetic: the sequencer performs no addition. Values wrap as two's complement at DIM_WIDTH exactly as the accumulator produces them; no saturation.
- in_last on the first chunk is legal (single-chunk dimension).
- in_valid=0 in ACCEPT: idle indefinitely; state and partial are preserved.

Optional Feature:
- Macro: HDSEQ_CHUNK_CHECK_EN.
- Defined:
  - Adds a chunk counter (0..NUM_CHUNKS-1), reset on each output handshake.
  - err (sticky until reset) is set if in_last is accepted on a chunk whose index is not NUM_CHUNKS-1.
  - err is also set if the chunk with index NUM_CHUNKS-1 is accepted with in_last=0; that chunk is then treated as last.
  - The output is still produced in both error cases.
- Undefined:
  - No counter and no err port.
  - in_last alone terminates the dimension.

Test Plan:
- Single chunk, features all 10, projections all 1, in_last=1 -> out_valid rises ACC_LATENCY+2 cycles after accept; out_data=320 (0x0140); acc_prev_result=0 during the chunk.
- Two chunks: features[i]=i with all projections 1, then features all 10 with all 1, in_last on chunk 2 -> acc_prev_result=496 during chunk 2; out_data=816.
- Single chunk, features all 10, projections[15:0]=0 and [31:16]=1 -> out_data=0. Second dimension with all projections 0 -> out_data=-320 (0xFEC0); first flag restarts with prev_result=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid and out_data stable; in_ready=0 throughout; the chunk offered meanwhile is accepted only after the handshake.
- Assert reset mid-WAIT of chunk 2 -> all outputs 0 immediately (asynchronous); the next dimension starts with acc_prev_result=0 and yields the correct single-dimension sum.
- With HDSEQ_CHUNK_CHECK_EN and NUM_CHUNKS=4: in_last on chunk 2 -> err=1 and output still produced. Separate run: 4 chunks without in_last -> output after chunk 4 and err=1. Correct 4-chunk run -> err=0.

Source files
------------

// File: rtl/hd_encode_sequencer.sv
// hd_encode_sequencer: initiator for the 32-lane mux accumulator of the HD encoder.
// Feeds one feature/projection chunk at a time, waits out the accumulator latency,
// feeds the captured result back as prev_result, and emits the finished dimension.
// Optional chunk-count checking (NUM_CHUNKS parameter, err port) with HDSEQ_CHUNK_CHECK_EN.
module hd_encode_sequencer #(
  parameter int unsigned INPUT_NUM   = 32,
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned DIM_WIDTH   = 16,
  parameter int unsigned ACC_LATENCY = 3
`ifdef HDSEQ_CHUNK_CHECK_EN
  ,
  parameter int unsigned NUM_CHUNKS  = 4
`endif
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INPUT_NUM*INPUT_WIDTH-1:0] in_features,
  input  logic [INPUT_NUM-1:0]           in_projections,
  input  logic                           in_last,
  output logic [INPUT_NUM*INPUT_WIDTH-1:0] acc_features,
  output logic [INPUT_NUM-1:0]           acc_projections,
  output logic [DIM_WIDTH-1:0]           acc_prev_result,
  input  logic [DIM_WIDTH-1:0]           acc_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DIM_WIDTH-1:0]           out_data
`ifdef HDSEQ_CHUNK_CHECK_EN
  ,
  output logic                           err
`endif
);

  localparam int unsigned CNT_W = (ACC_LATENCY < 1) ? 1 : $clog2(ACC_LATENCY + 1);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_WAIT   = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 first_q;
  logic                 last_q;
  logic [DIM_WIDTH-1:0] partial_q;
  logic                 accept_c;
  logic                 capture_c;
  logic                 handshake_c;
  logic                 eff_last_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_ACCEPT;
    else        state_q <= state_d;
  end

  // Next-state decode and per-edge strobes; in_ready depends on state only
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    accept_c    = 1'b0;
    capture_c   = 1'b0;
    handshake_c = 1'b0;
    unique case (state_q)
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          capture_c = 1'b1;
          state_d   = last_q ? S_OUTPUT : S_ACCEPT;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          handshake_c = 1'b1;
          state_d     = S_ACCEPT;
        end
      end
      default: state_d = S_ACCEPT;
    endcase
  end

`ifdef HDSEQ_CHUNK_CHECK_EN
  localparam int unsigned IDX_W = (NUM_CHUNKS < 2) ? 1 : $clog2(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  logic [IDX_W-1:0] idx_q;
  logic             at_last_idx_c;

  assign at_last_idx_c = (idx_q == LAST_IDX);
  // The final permitted chunk closes the dimension even without in_last
  assign eff_last_c    = in_last | at_last_idx_c;

  // Chunk index within the dimension and sticky count error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      err   <= 1'b0;
    end else begin
      if (handshake_c)
        idx_q <= '0;
      else if (accept_c && !eff_last_c)
        idx_q <= idx_q + IDX_W'(1);
      if (accept_c && (in_last != at_last_idx_c))
        err <= 1'b1;
    end
  end
`else
  assign eff_last_c = in_last;
`endif

  // Chunk launch, latency countdown, result capture and output hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_features    <= '0;
      acc_projections <= '0;
      acc_prev_result <= '0;
      cnt_q           <= '0;
      first_q         <= 1'b1;
      last_q          <= 1'b0;
      partial_q       <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
    end else begin
      if (accept_c) begin
        acc_features    <= in_features;
        acc_projections <= in_projections;
        acc_prev_result <= first_q ? '0 : partial_q;
        last_q          <= eff_last_c;
        first_q         <= 1'b0;
        cnt_q           <= CNT_W'(ACC_LATENCY);
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (capture_c) begin
        partial_q <= acc_out;
        if (last_q) begin
          out_data  <= acc_out;
          out_valid <= 1'b1;
        end
      end

      if (handshake_c) begin
        out_valid <= 1'b0;
        first_q   <= 1'b1;
        partial_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hd_encode_sequencer.sv
// Bench for hd_encode_sequencer: behavioural accumulator, scoreboard of finished
// dimension values, and a monitor that checks output handshakes and hold behaviour.
module tb_hd_encode_sequencer;

  localparam int unsigned N   = 32;
  localparam int unsigned IW  = 8;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 3;
  localparam int unsigned FW  = N * IW;
`ifdef HDSEQ_CHUNK_CHECK_EN
  localparam int unsigned NCH = 4;
  logic err;
  int   m_idx;
  bit   m_err;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_features;
  logic [N-1:0]  in_projections;
  logic          in_last;
  logic [FW-1:0] acc_features;
  logic [N-1:0]  acc_projections;
  logic [DW-1:0] acc_prev_result;
  logic [DW-1:0] acc_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  int            total;
  int            bad;
  logic [DW-1:0] sb[$];
  bit            bp_hold;
  logic [DW-1:0] m_partial;
  bit            m_first;
  int            hs_count;
  int            hs_at_accept;
  logic          prev_hold;
  logic [DW-1:0] prev_data;

  hd_encode_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_features     (in_features),
    .in_projections  (in_projections),
    .in_last         (in_last),
    .acc_features    (acc_features),
    .acc_projections (acc_projections),
    .acc_prev_result (acc_prev_result),
    .acc_out         (acc_out),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data)
`ifdef HDSEQ_CHUNK_CHECK_EN
    ,
    .err             (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed chunk contribution: +feature where projection is 1, -feature otherwise
  function automatic logic [DW-1:0] chunk_sum(input logic [FW-1:0] f, input logic [N-1:0] p);
    int s;
    int v;
    s = 0;
    for (int i = 0; i < N; i++) begin
      v = 0;
      v[IW-1:0] = f[i*IW +: IW];
      if (p[i]) s = s + v;
      else      s = s - v;
    end
    return DW'(s);
  endfunction

  function automatic logic [FW-1:0] const_feat(input int val);
    logic [FW-1:0] f;
    for (int i = 0; i < N; i++) f[i*IW +: IW] = IW'(val);
    return f;
  endfunction

  // Accumulator stand-in: result appears LAT edges after its inputs settle
  logic [DW-1:0] pipe [LAT];
  assign acc_out = pipe[LAT-1];
  always @(posedge clk) begin
    pipe[0] <= acc_prev_result + chunk_sum(acc_features, acc_projections);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Downstream ready: random, or forced low while bp_hold
  always @(posedge clk) begin
    #1;
    out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Output monitor: handshake scoreboard, hold stability, no input accept while presenting
  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_low_in_output", 64'(in_ready), 64'(0));
        if (prev_hold) check("out_data_stable", 64'(out_data), 64'(prev_data));
        if (out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got 0x%0h want no output", out_data);
          end else begin
            check("out_data", 64'(out_data), 64'(sb.pop_front()));
          end
          hs_count++;
        end
      end else if (prev_hold) begin
        check("out_valid_held", 64'(out_valid), 64'(1));
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic rand_chunk(output logic [FW-1:0] f, output logic [N-1:0] p);
    for (int i = 0; i < N; i++) f[i*IW +: IW] = IW'($urandom_range(0, 127));
    p = N'($urandom());
  endtask

  task automatic model_reset();
    m_first   = 1'b1;
    m_partial = '0;
`ifdef HDSEQ_CHUNK_CHECK_EN
    m_idx = 0;
    m_err = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Offer one chunk (called at a negedge); want<0 means use the model's sum
  task automatic send_chunk(input logic [FW-1:0] f, input logic [N-1:0] p, input bit last,
                            input int want, output bit done);
    logic [DW-1:0] exp_prev;
    bit            eff_last;
    int            guard;
    int            lat;
    exp_prev = m_first ? '0 : m_partial;
    eff_last = last;
`ifdef HDSEQ_CHUNK_CHECK_EN
    if (last != (m_idx == NCH - 1)) m_err = 1'b1;
    if (m_idx == NCH - 1) eff_last = 1'b1;
`endif
    in_features    = f;
    in_projections = p;
    in_last        = last;
    in_valid       = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stuck at 0 want 1");
      in_valid = 1'b0;
      done = 1'b1;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    hs_at_accept = hs_count;
    check("acc_prev_result", 64'(acc_prev_result), 64'(exp_prev));
    check("acc_features", 64'(acc_features[63:0]), 64'(f[63:0]));
    check("acc_projections", 64'(acc_projections), 64'(p));
    m_partial = exp_prev + chunk_sum(f, p);
    m_first   = 1'b0;
`ifdef HDSEQ_CHUNK_CHECK_EN
    check("err", 64'(err), 64'(m_err));
    m_idx = eff_last ? 0 : m_idx + 1;
`endif
    done = eff_last;
    if (eff_last) begin
      sb.push_back((want < 0) ? m_partial : DW'(want));
      m_first = 1'b1;
      lat = 1;
      while (!out_valid && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check("out_valid_latency", 64'(lat), 64'(LAT + 2));
    end
  endtask

  initial begin
    logic [FW-1:0] f;
    logic [FW-1:0] ramp;
    logic [N-1:0]  p;
    bit            done;
    int            hs0;
    int            guard;
    total = 0;
    bad = 0;
    hs_count = 0;
    hs_at_accept = 0;
    bp_hold = 1'b0;
    prev_hold = 1'b0;
    prev_data = '0;
    reset = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_features = '0;
    in_projections = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_acc_prev", 64'(acc_prev_result), 64'(0));
    check("rst_acc_proj", 64'(acc_projections), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Single chunk, all +10
    send_chunk(const_feat(10), '1, 1'b1, 320, done);
    // Two chunks: ramp then all +10
    for (int i = 0; i < N; i++) ramp[i*IW +: IW] = IW'(i);
    send_chunk(ramp, '1, 1'b0, 496, done);
    send_chunk(const_feat(10), '1, 1'b1, 816, done);
    // Half cancel, then all negative
    send_chunk(const_feat(10), {16'hFFFF, 16'h0000}, 1'b1, 0, done);
    send_chunk(const_feat(10), '0, 1'b1, 65216, done);

    // Backpressure: hold out_ready low, offer the next chunk meanwhile
    bp_hold = 1'b1;
    send_chunk(const_feat(10), '1, 1'b1, 320, done);
    hs0 = hs_count;
    fork
      begin
        repeat (5) @(negedge clk);
        bp_hold = 1'b0;
      end
    join_none
    rand_chunk(f, p);
    send_chunk(f, p, 1'b1, -1, done);
    check("accept_after_handshake", 64'(hs_at_accept), 64'(hs0 + 1));

    // Reset in the middle of the second chunk's wait
    rand_chunk(f, p);
    send_chunk(f, p, 1'b0, -1, done);
    rand_chunk(f, p);
    send_chunk(f, p, 1'b0, -1, done);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_out_data", 64'(out_data), 64'(0));
    check("mid_rst_acc_prev", 64'(acc_prev_result), 64'(0));
    check("mid_rst_acc_feat", 64'(acc_features[63:0]), 64'(0));
    check("mid_rst_acc_proj", 64'(acc_projections), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    rand_chunk(f, p);
    send_chunk(f, p, 1'b1, -1, done);

`ifdef HDSEQ_CHUNK_CHECK_EN
    // Early in_last on the second chunk
    do_reset();
    rand_chunk(f, p);
    send_chunk(f, p, 1'b0, -1, done);
    rand_chunk(f, p);
    send_chunk(f, p, 1'b1, -1, done);
    check("err_early_last", 64'(err), 64'(1));
    // Four chunks with no in_last: the fourth closes the dimension
    do_reset();
    done = 1'b0;
    for (int c = 0; c < 4 && !done; c++) begin
      rand_chunk(f, p);
      send_chunk(f, p, 1'b0, -1, done);
    end
    check("err_missing_last", 64'(err), 64'(1));
    // Correct four-chunk dimension
    do_reset();
    done = 1'b0;
    for (int c = 0; c < 4 && !done; c++) begin
      rand_chunk(f, p);
      send_chunk(f, p, c == 3, -1, done);
    end
    check("err_clean", 64'(err), 64'(0));
`endif

    // Random dimensions with idle gaps
    do_reset();
    for (int d = 0; d < 30; d++) begin
      int n;
      n = $urandom_range(1, 4);
      done = 1'b0;
      for (int c = 0; c < n && !done; c++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rand_chunk(f, p);
        send_chunk(f, p, c == n - 1, -1, done);
      end
    end

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d outputs still pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
